simd_alu_pipe: RTL and testbench

Parametrised, handshaked successor of the four-lane 8-bit SIMD ALU. It applies an independent per-lane opcode to LANES slices of LANE_W bits. The result register sits behind a valid/ready interface, and an iterative divider replaces the combinational divide. It sits between the operand-fetch stage and the result-writeback stage of the SIMD datapath.

---
 rtl/simd_alu_pipe.sv | 181 ++++++++++++++++++
 tb/tb_simd_alu_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: LANES-wide SIMD ALU behind a valid/ready handshake.
// Single-cycle ops are registered on acceptance. Bundles holding any div/rem
// lane run a restoring divider for LANE_W cycles before results are offered.
module simd_alu_pipe #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*LANE_W-1:0]     a,
    input  logic [LANES*LANE_W-1:0]     b,
    input  logic [LANES-1:0]            cin,
    input  logic [4*LANES-1:0]          opcode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*LANE_W*LANES-1:0]   out,
    output logic [LANES-1:0]            carry,
    output logic [LANES-1:0]            dz
);

    localparam int CNT_W = $clog2(LANE_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANE_W - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [LANE_W-1:0] div_q  [LANES];
    logic [LANE_W-1:0] div_r  [LANES];
    logic [LANE_W-1:0] div_d  [LANES];
    logic [LANE_W-1:0] q_next [LANES];
    logic [LANE_W-1:0] r_next [LANES];
    logic [LANES-1:0]  div_lane;
    logic [LANES-1:0]  rem_lane;
    logic              any_div;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == 4'h3) || (op == 4'hB);
    endfunction

    // Single-cycle lane result; returns {carry, zero-extended result}.
    // Div/rem and unused opcodes yield zero here.
    function automatic logic [2*LANE_W:0] lane_alu(input logic [3:0]        op,
                                                   input logic [LANE_W-1:0] x,
                                                   input logic [LANE_W-1:0] y,
                                                   input logic              ci);
        logic [LANE_W:0]     sum;
        logic [LANE_W:0]     diff;
        logic [2*LANE_W-1:0] res;
        logic                c;
        sum  = {1'b0, x} + {1'b0, y} + {{LANE_W{1'b0}}, ci};
        diff = {1'b0, x} - {1'b0, y} - {{LANE_W{1'b0}}, ci};
        res  = '0;
        c    = 1'b0;
        case (op)
            4'h0: begin res = {{LANE_W{1'b0}}, sum[LANE_W-1:0]};  c = sum[LANE_W];  end
            4'h1: begin res = {{LANE_W{1'b0}}, diff[LANE_W-1:0]}; c = diff[LANE_W]; end
            4'h2: res = {{LANE_W{1'b0}}, x} * {{LANE_W{1'b0}}, y};
            4'h4: res = {{LANE_W{1'b0}}, x & y};
            4'h5: res = {{LANE_W{1'b0}}, x | y};
            4'h6: res = {{LANE_W{1'b0}}, x ^ y};
            4'h7: res = {{LANE_W{1'b0}}, ~x};
            4'h8: begin res = {{LANE_W{1'b0}}, 1'b0, x[LANE_W-1:1]}; c = x[0]; end
            4'h9: begin res = {{LANE_W{1'b0}}, x[LANE_W-2:0], 1'b0}; c = x[LANE_W-1]; end
            4'hA: begin
                if (sum[LANE_W]) begin
                    res = {{LANE_W{1'b0}}, {LANE_W{1'b1}}};
                    c   = 1'b1;
                end else begin
                    res = {{LANE_W{1'b0}}, sum[LANE_W-1:0]};
                end
            end
            default: ;
        endcase
        return {c, res};
    endfunction

    // One restoring-divide step; returns {remainder, quotient/dividend}.
    // A zero divisor never restores, so it naturally ends with an all-ones
    // quotient and the dividend as remainder.
    function automatic logic [2*LANE_W-1:0] div_step(input logic [LANE_W-1:0] r,
                                                     input logic [LANE_W-1:0] q,
                                                     input logic [LANE_W-1:0] d);
        logic [LANE_W:0] shifted;
        logic [LANE_W:0] trial;
        shifted = {r, q[LANE_W-1]};
        trial   = shifted - {1'b0, d};
        if (!trial[LANE_W]) begin
            return {trial[LANE_W-1:0], q[LANE_W-2:0], 1'b1};
        end
        return {shifted[LANE_W-1:0], q[LANE_W-2:0], 1'b0};
    endfunction

    // Next divider state for every lane.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            {r_next[i], q_next[i]} = div_step(div_r[i], div_q[i], div_d[i]);
        end
    end

    // Flags whether the offered bundle needs the iterative divider.
    always_comb begin
        any_div = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (is_div_op(opcode[4*i +: 4])) any_div = 1'b1;
        end
    end

    // Control FSM with registered handshake outputs, result and divider state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            carry     <= '0;
            dz        <= '0;
            count     <= '0;
            div_lane  <= '0;
            rem_lane  <= '0;
            for (int i = 0; i < LANES; i++) begin
                div_q[i] <= '0;
                div_r[i] <= '0;
                div_d[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            {carry[i], out[2*LANE_W*i +: 2*LANE_W]} <=
                                lane_alu(opcode[4*i +: 4], a[LANE_W*i +: LANE_W],
                                         b[LANE_W*i +: LANE_W], cin[i]);
                            div_lane[i] <= is_div_op(opcode[4*i +: 4]);
                            rem_lane[i] <= (opcode[4*i +: 4] == 4'hB);
                            dz[i]       <= is_div_op(opcode[4*i +: 4]) &&
                                           (b[LANE_W*i +: LANE_W] == '0);
                            div_q[i]    <= a[LANE_W*i +: LANE_W];
                            div_r[i]    <= '0;
                            div_d[i]    <= b[LANE_W*i +: LANE_W];
                        end
                        count    <= '0;
                        in_ready <= 1'b0;
                        if (any_div) begin
                            state <= EXEC;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    for (int i = 0; i < LANES; i++) begin
                        div_q[i] <= q_next[i];
                        div_r[i] <= r_next[i];
                        if (div_lane[i] && (count == LAST)) begin
                            out[2*LANE_W*i +: 2*LANE_W] <=
                                {{LANE_W{1'b0}}, rem_lane[i] ? r_next[i] : q_next[i]};
                        end
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: drives a 4x8 and a 2x16 instance with directed and random
// bundles and compares against a lane-level arithmetic reference model.
module tb_simd_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        in_valid_4, in_ready_4, out_valid_4, out_ready_4;
    logic [31:0] a_4, b_4;
    logic [3:0]  cin_4, carry_4, dz_4;
    logic [15:0] opcode_4;
    logic [63:0] out_4;

    logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16;
    logic [31:0] a_16, b_16;
    logic [1:0]  cin_16, carry_16, dz_16;
    logic [7:0]  opcode_16;
    logic [63:0] out_16;

    int compared   = 0;
    int mismatched = 0;

    simd_alu_pipe #(.LANES(4), .LANE_W(8)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_4), .in_ready(in_ready_4),
        .a(a_4), .b(b_4), .cin(cin_4), .opcode(opcode_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .out(out_4), .carry(carry_4), .dz(dz_4)
    );

    simd_alu_pipe #(.LANES(2), .LANE_W(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_16), .in_ready(in_ready_16),
        .a(a_16), .b(b_16), .cin(cin_16), .opcode(opcode_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16),
        .out(out_16), .carry(carry_16), .dz(dz_16)
    );

    // Read-back helpers selecting instance 0 (4x8) or 1 (2x16).
    function automatic logic dut_out_valid(input int inst);
        return (inst == 0) ? out_valid_4 : out_valid_16;
    endfunction
    function automatic logic dut_in_ready(input int inst);
        return (inst == 0) ? in_ready_4 : in_ready_16;
    endfunction
    function automatic logic [63:0] dut_out(input int inst);
        return (inst == 0) ? out_4 : out_16;
    endfunction
    function automatic logic [3:0] dut_carry(input int inst);
        return (inst == 0) ? carry_4 : {2'b00, carry_16};
    endfunction
    function automatic logic [3:0] dut_dz(input int inst);
        return (inst == 0) ? dz_4 : {2'b00, dz_16};
    endfunction

    task automatic set_out_ready(input int inst, input logic v);
        if (inst == 0) out_ready_4 = v; else out_ready_16 = v;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour of one lane, straight from the opcode definitions.
    function automatic void lane_model(input int op, input longint x, input longint y,
                                       input longint ci, input int w,
                                       output longint r, output bit c, output bit z);
        longint mask;
        longint s;
        longint d;
        mask = (longint'(1) << w) - 1;
        s = x + y + ci;
        d = x - y - ci;
        r = 0; c = 0; z = 0;
        case (op)
            0:  begin r = s & mask; c = (s > mask); end
            1:  begin r = d & mask; c = (d < 0); end
            2:  r = x * y;
            3:  if (y == 0) begin r = mask; z = 1; end else r = x / y;
            4:  r = x & y;
            5:  r = x | y;
            6:  r = x ^ y;
            7:  r = ~x & mask;
            8:  begin r = x / 2; c = (x % 2) == 1; end
            9:  begin r = (x * 2) & mask; c = (x > mask / 2); end
            10: if (s > mask) begin r = mask; c = 1; end else r = s;
            11: if (y == 0) begin r = x; z = 1; end else r = x % y;
            default: ;
        endcase
    endfunction

    task automatic build_expect(input int lanes, input int w,
                                input logic [31:0] av, input logic [31:0] bv,
                                input logic [3:0] cv, input logic [15:0] ov,
                                output logic [63:0] eo, output logic [3:0] ec,
                                output logic [3:0] ed, output int elat);
        longint mask, x, y, ci, r;
        bit c, z;
        int op;
        mask = (longint'(1) << w) - 1;
        eo = '0; ec = '0; ed = '0; elat = 1;
        for (int i = 0; i < lanes; i++) begin
            x  = longint'(av >> (w * i)) & mask;
            y  = longint'(bv >> (w * i)) & mask;
            ci = longint'((cv >> i) & 4'h1);
            op = int'((ov >> (4 * i)) & 16'hF);
            lane_model(op, x, y, ci, w, r, c, z);
            eo = eo | (64'(r) << (2 * w * i));
            ec[i] = c;
            ed[i] = z;
            if (op == 3 || op == 11) elat = w + 1;
        end
    endtask

    // Offers a bundle, waits (bounded) for acceptance, then scrambles the inputs.
    task automatic apply_stimulus(input int inst, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [3:0] cv, input logic [15:0] ov);
        int n;
        n = 0;
        @(negedge clk);
        if (inst == 0) begin
            a_4 = av; b_4 = bv; cin_4 = cv; opcode_4 = ov; in_valid_4 = 1'b1;
        end else begin
            a_16 = av; b_16 = bv; cin_16 = cv[1:0]; opcode_16 = ov[7:0]; in_valid_16 = 1'b1;
        end
        while (!dut_in_ready(inst) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("accept_ready", {63'b0, dut_in_ready(inst)}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_4  = 1'b0;
        in_valid_16 = 1'b0;
        a_4 = $urandom; b_4 = $urandom; a_16 = $urandom; b_16 = $urandom;
    endtask

    task automatic run_bundle(input int inst, input string tag,
                              input logic [31:0] av, input logic [31:0] bv,
                              input logic [3:0] cv, input logic [15:0] ov,
                              output logic [63:0] got_out, output logic [3:0] got_carry,
                              output logic [3:0] got_dz);
        logic [63:0] eo;
        logic [3:0]  ec, ed;
        int          elat, lat;
        build_expect((inst == 0) ? 4 : 2, (inst == 0) ? 8 : 16, av, bv, cv, ov, eo, ec, ed, elat);
        apply_stimulus(inst, av, bv, cv, ov);
        lat = 1;
        while (!dut_out_valid(inst) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got_out   = dut_out(inst);
        got_carry = dut_carry(inst);
        got_dz    = dut_dz(inst);
        check_output($sformatf("%s_lat", tag), 64'(lat), 64'(elat));
        check_output($sformatf("%s_out", tag), got_out, eo);
        check_output($sformatf("%s_carry", tag), {60'b0, got_carry}, {60'b0, ec});
        check_output($sformatf("%s_dz", tag), {60'b0, got_dz}, {60'b0, ed});
        set_out_ready(inst, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_out_ready(inst, 1'b0);
        check_output($sformatf("%s_ready_after", tag), {63'b0, dut_in_ready(inst)}, 64'd1);
        check_output($sformatf("%s_valid_after", tag), {63'b0, dut_out_valid(inst)}, 64'd0);
    endtask

    // Safety net in case a wait is ever left unbounded.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] go, eo_x, eo_y;
        logic [3:0]  gc, gd, ec_x, ed_x, ec_y, ed_y;
        logic [31:0] ra, rb;
        int          el_x, el_y, lat;

        reset = 1'b0;
        in_valid_4 = 1'b0; out_ready_4 = 1'b0; a_4 = '0; b_4 = '0; cin_4 = '0; opcode_4 = '0;
        in_valid_16 = 1'b0; out_ready_16 = 1'b0; a_16 = '0; b_16 = '0; cin_16 = '0; opcode_16 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");
        check_output("rst_in_ready", {63'b0, in_ready_4}, 64'd1);
        check_output("rst_out_valid", {63'b0, out_valid_4}, 64'd0);
        check_output("rst_out", out_4, 64'd0);
        check_output("rst_carry_dz", {56'b0, carry_4, dz_4}, 64'd0);
        check_output("rst16_in_ready", {63'b0, in_ready_16}, 64'd1);
        check_output("rst16_out_valid", {63'b0, out_valid_16}, 64'd0);

        // Add/sub mix
        run_bundle(0, "addsub", 32'hFF10_8001, 32'h0120_8001, 4'b0001, 16'h1000, go, gc, gd);
        check_output("addsub_out_const", go, 64'h00FE_0030_0000_0003);
        check_output("addsub_carry_const", {60'b0, gc}, 64'h2);

        // Multiply / saturate / shift / unused opcode
        run_bundle(0, "mulsat", 32'h0081_F0FF, 32'h0000_20FF, 4'b0000, 16'hE9A2, go, gc, gd);
        check_output("mulsat_out_const", go, 64'h0000_0002_00FF_FE01);
        check_output("mulsat_carry_const", {60'b0, gc}, 64'h6);

        // Divide, remainder and divide-by-zero lanes
        run_bundle(0, "div", 32'h0909_C8C8, 32'h0000_0707, 4'b0000, 16'hB3B3, go, gc, gd);
        check_output("div_out_const", go, 64'h0009_00FF_0004_001C);
        check_output("div_dz_const", {60'b0, gd}, 64'hC);

        // Wide instance: 65535/255 plus a borrowing subtract
        run_bundle(1, "div16", 32'h0005_FFFF, 32'h0007_00FF, 4'b0000, 16'h0013, go, gc, gd);
        check_output("div16_out_const", go, 64'h0000_FFFE_0000_0101);
        check_output("div16_carry_const", {60'b0, gc}, 64'h2);

        // Backpressure: result held, second bundle waits until handshake
        build_expect(4, 8, 32'hFF10_8001, 32'h0120_8001, 4'b0001, 16'h1000, eo_x, ec_x, ed_x, el_x);
        build_expect(4, 8, 32'h0081_F0FF, 32'h0000_20FF, 4'b0000, 16'hE9A2, eo_y, ec_y, ed_y, el_y);
        apply_stimulus(0, 32'hFF10_8001, 32'h0120_8001, 4'b0001, 16'h1000);
        lat = 1;
        while (!out_valid_4 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        a_4 = 32'h0081_F0FF; b_4 = 32'h0000_20FF; cin_4 = 4'b0000; opcode_4 = 16'hE9A2;
        in_valid_4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_output("bp_hold_out", out_4, eo_x);
            check_output("bp_hold_valid", {63'b0, out_valid_4}, 64'd1);
            check_output("bp_hold_in_ready", {63'b0, in_ready_4}, 64'd0);
            @(negedge clk);
        end
        out_ready_4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_4 = 1'b0;
        check_output("bp_release_ready", {63'b0, in_ready_4}, 64'd1);
        check_output("bp_release_valid", {63'b0, out_valid_4}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid_4 = 1'b0;
        check_output("bp_second_valid", {63'b0, out_valid_4}, 64'd1);
        check_output("bp_second_out", out_4, eo_y);
        check_output("bp_second_carry", {60'b0, carry_4}, {60'b0, ec_y});
        out_ready_4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_4 = 1'b0;

        // Reset while the divider is running discards the bundle
        apply_stimulus(0, 32'h1122_33C8, 32'h0101_0107, 4'b0000, 16'h0003);
        repeat (3) @(negedge clk);
        check_output("midexec_valid", {63'b0, out_valid_4}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("inrst_out", out_4, 64'd0);
        check_output("inrst_carry_dz", {56'b0, carry_4, dz_4}, 64'd0);
        check_output("inrst_valid", {63'b0, out_valid_4}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("postrst_ready", {63'b0, in_ready_4}, 64'd1);
        repeat (12) @(negedge clk);
        check_output("postrst_discarded", {63'b0, out_valid_4}, 64'd0);

        // Random bundles on both instances
        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb[7:0] = 8'h00;
            run_bundle(0, "rand4", ra, rb, 4'($urandom_range(0, 15)), 16'($urandom), go, gc, gd);
        end
        for (int t = 0; t < 16; t++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb[15:0] = 16'h0000;
            run_bundle(1, "rand16", ra, rb, 4'($urandom_range(0, 3)), 16'($urandom_range(0, 255)), go, gc, gd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
